// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared constants and types for the convolution engine
//                post-processing stages (pixel format, image geometry,
//                memory select codes, max-pool FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Signed 4.16 fixed-point pixel
    localparam int DATA_WIDTH = 20;
    // Layer-0 side length (must be even)
    localparam int IMG_W      = 64;
    // Shared result memory address width
    localparam int ADDR_W     = 12;
    // Cycles from read strobe to valid read data
    localparam int RD_LAT     = 1;

    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } pool_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_maxpool_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_maxpool_if
//  Description : Control handshake and result-memory bus of the max-pool
//                stage.
//                master : the pooling engine (drives strobes/addresses/data)
//                slave  : controller + shared result memory
//  Signals     : start, busy, done            - controller handshake
//                crd, caddr_rd, cdata_rd      - memory read port
//                cwr, caddr_wr, cdata_wr      - memory write port
//                csel                         - memory layer select
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_maxpool_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH
) ();

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  crd;
    logic [ADDR_W-1:0]     caddr_rd;
    logic [DATA_WIDTH-1:0] cdata_rd;
    logic                  cwr;
    logic [ADDR_W-1:0]     caddr_wr;
    logic [DATA_WIDTH-1:0] cdata_wr;
    logic [2:0]            csel;

    modport master (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

endinterface
`default_nettype wire

// File: rtl/conv_maxpool_pool_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pool_addr_gen
//  Description : Window/tap counters for 2x2 stride-2 max-pooling.
//                Holds window row r, column c and tap k; decodes the
//                layer-0 read address and the layer-1 write address from
//                those registers.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                i_tap_step     - advance tap k (wraps 3 -> 0)
//                i_win_step     - advance window (c, then r on c wrap)
//                o_rd_addr      - base + {0, 1, IMG_W, IMG_W+1}[k]
//                o_wr_addr      - r*(IMG_W/2) + c
//                o_first_tap    - k == 0
//                o_last_tap     - k == 3
//                o_last_win     - r and c both at their last value
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = conv_pkg::IMG_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_tap_step,
    input  wire logic              i_win_step,
    output logic [ADDR_W-1:0]      o_rd_addr,
    output logic [ADDR_W-1:0]      o_wr_addr,
    output logic                   o_first_tap,
    output logic                   o_last_tap,
    output logic                   o_last_win
);

    localparam int                c_HALF    = IMG_W / 2;
    localparam int                c_RC_W    = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [c_RC_W-1:0] c_RC_LAST = c_RC_W'(c_HALF - 1);

    logic [c_RC_W-1:0] r_row;
    logic [c_RC_W-1:0] r_col;
    logic [1:0]        r_tap;
    logic [ADDR_W-1:0] w_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
            r_tap <= '0;
        end else begin
            if (i_tap_step) begin
                r_tap <= r_tap + 2'd1;
            end
            if (i_win_step) begin
                if (r_col == c_RC_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_RC_LAST) ? '0 : r_row + c_RC_W'(1);
                end else begin
                    r_col <= r_col + c_RC_W'(1);
                end
            end
        end
    end

    // Top-left pixel of window (r, c) in layer 0: 2r*IMG_W + 2c
    assign w_base      = (ADDR_W'(r_row) * ADDR_W'(2 * IMG_W)) + (ADDR_W'(r_col) << 1);
    // Tap bit 0 selects the right column, bit 1 the lower row
    assign o_rd_addr   = w_base + ADDR_W'(r_tap[0]) + (r_tap[1] ? ADDR_W'(IMG_W) : '0);
    assign o_wr_addr   = (ADDR_W'(r_row) * ADDR_W'(c_HALF)) + ADDR_W'(r_col);
    assign o_first_tap = (r_tap == 2'd0);
    assign o_last_tap  = (r_tap == 2'd3);
    assign o_last_win  = (r_row == c_RC_LAST) && (r_col == c_RC_LAST);

endmodule
`default_nettype wire

// File: rtl/conv_maxpool.sv
`default_nettype none
// ============================================================================
//  Module      : conv_maxpool
//  Description : 2x2 stride-2 max-pooling of layer 0 (IMG_W x IMG_W) into
//                layer 1 (IMG_W/2 x IMG_W/2) of the shared result memory.
//                Per window: 4 reads, RD_LAT drain cycles, 1 write.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-high reset
//                bus    - conv_maxpool_if.master (handshake + memory bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_maxpool
    import conv_pkg::*;
#(
    parameter int         DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int         IMG_W      = conv_pkg::IMG_W,
    parameter int         RD_LAT     = conv_pkg::RD_LAT,
    parameter logic [2:0] SEL_L0     = conv_pkg::SEL_L0,
    parameter logic [2:0] SEL_L1     = conv_pkg::SEL_L1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    conv_maxpool_if.master bus
);

    localparam int                 c_DRN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(RD_LAT - 1);

    pool_state_t           r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_crd;
    logic                  r_cwr;
    logic [2:0]            r_csel;
    logic [DATA_WIDTH-1:0] r_cdata_wr;
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] w_max_next;
    logic [c_DRN_W-1:0]    r_drain;
    // Track each read strobe (and whether it was tap 0) until its data returns
    logic [RD_LAT-1:0]     r_vld_pipe;
    logic [RD_LAT-1:0]     r_first_pipe;

    logic                  w_tap_step;
    logic                  w_win_step;
    logic [ADDR_W-1:0]     w_caddr_rd;
    logic [ADDR_W-1:0]     w_caddr_wr;
    logic                  w_first_tap;
    logic                  w_last_tap;
    logic                  w_last_win;

    assign w_tap_step = (r_state == S_READ);
    assign w_win_step = (r_state == S_WRITE);

    pool_addr_gen #(
        .IMG_W (IMG_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (reset),
        .i_tap_step  (w_tap_step),
        .i_win_step  (w_win_step),
        .o_rd_addr   (w_caddr_rd),
        .o_wr_addr   (w_caddr_wr),
        .o_first_tap (w_first_tap),
        .o_last_tap  (w_last_tap),
        .o_last_win  (w_last_win)
    );

    // First sample of a window loads unconditionally; later ones only when
    // strictly greater, so ties keep the earlier sample.
    always_comb begin
        w_max_next = r_max;
        if (r_vld_pipe[RD_LAT-1]) begin
            if (r_first_pipe[RD_LAT-1] || ($signed(bus.cdata_rd) > $signed(r_max))) begin
                w_max_next = bus.cdata_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_pipe   <= '0;
            r_first_pipe <= '0;
            r_max        <= '0;
        end else begin
            r_vld_pipe[0]   <= r_crd;
            r_first_pipe[0] <= r_crd & w_first_tap;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]   <= r_vld_pipe[i-1];
                r_first_pipe[i] <= r_first_pipe[i-1];
            end
            r_max <= w_max_next;
        end
    end

    // Outputs are registered alongside the state so each reflects the state
    // being entered. cdata_wr takes w_max_next because the final tap is
    // captured on the same edge that enters WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_crd      <= 1'b0;
            r_cwr      <= 1'b0;
            r_csel     <= 3'b000;
            r_cdata_wr <= '0;
            r_drain    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                        r_crd   <= 1'b1;
                        r_csel  <= SEL_L0;
                    end
                end
                S_READ: begin
                    if (w_last_tap) begin
                        r_state <= S_DRAIN;
                        r_crd   <= 1'b0;
                        r_csel  <= 3'b000;
                        r_drain <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == c_DRN_LAST) begin
                        r_state    <= S_WRITE;
                        r_cwr      <= 1'b1;
                        r_csel     <= SEL_L1;
                        r_cdata_wr <= w_max_next;
                    end else begin
                        r_drain <= r_drain + c_DRN_W'(1);
                    end
                end
                S_WRITE: begin
                    r_cwr <= 1'b0;
                    if (w_last_win) begin
                        r_state <= S_FIN;
                        r_csel  <= 3'b000;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                        r_crd   <= 1'b1;
                        r_csel  <= SEL_L0;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_crd   <= 1'b0;
                    r_cwr   <= 1'b0;
                    r_csel  <= 3'b000;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.crd      = r_crd;
    assign bus.cwr      = r_cwr;
    assign bus.csel     = r_csel;
    assign bus.cdata_wr = r_cdata_wr;
    assign bus.caddr_rd = w_caddr_rd;
    assign bus.caddr_wr = w_caddr_wr;

endmodule
`default_nettype wire

// File: doc/conv_maxpool.md
# conv_maxpool

- Downstream stage of the convolution engine. Runs once the 64×64 layer-0 result (convolution + bias + ReLU) is complete in shared result memory.
- Applies 2×2, stride-2 max-pooling to layer 0 and writes the 32×32 result to layer 1 of the same memory.
- Started by the convolution controller with a single-cycle `start`. Owns the memory read/write ports until it pulses `done`.

## Interface
Parameters:
- DATA_WIDTH, 20, signed pixel width (4 integer . 16 fraction)
- IMG_W, 64, layer-0 side length; must be even
- RD_LAT, 1, cycles from `crd` to valid `cdata_rd`
- SEL_L0, 3'b001, `csel` code for layer-0 reads
- SEL_L1, 3'b011, `csel` code for layer-1 writes

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request from the convolution controller
- busy  out  1  high from the cycle after an accepted `start` until `done`
- done  out  1  one-cycle pulse after the last layer-1 write
- crd  out  1  memory read strobe
- caddr_rd  out  12  read address
- cdata_rd  in  DATA_WIDTH  read data, valid RD_LAT cycles after `crd`
- cwr  out  1  memory write strobe
- caddr_wr  out  12  write address, zero-extended
- cdata_wr  out  DATA_WIDTH  write data
- csel  out  3  memory select: SEL_L0 during reads, SEL_L1 during writes, 0 otherwise

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE, FIN.
- IDLE
  - `start` → READ; window row r and column c set to 0.
  - `start` while not IDLE is ignored.
- READ (4 cycles, k = 0..3)
  - `crd` = 1, `csel` = SEL_L0.
  - `caddr_rd` = base, base+1, base+IMG_W, base+IMG_W+1, where base = 2r·IMG_W + 2c.
- DRAIN: RD_LAT cycles; `crd` = 0; the last sample is captured.
- Max accumulation
  - The first returned sample loads `max_reg`.
  - Each later sample replaces `max_reg` only if strictly greater (signed compare).
  - On ties the earlier sample is kept.
- WRITE (1 cycle)
  - `cwr` = 1, `csel` = SEL_L1.
  - `caddr_wr` = r·(IMG_W/2) + c.
  - `cdata_wr` = `max_reg`.
  - Then advance c. On c wrap (IMG_W/2−1 → 0), increment r.
  - After window (IMG_W/2−1, IMG_W/2−1) → FIN; otherwise → READ.
- FIN: `done` = 1 for one cycle, `busy` drops in the same cycle, → IDLE.
- `crd` and `cwr` are never high together.
- `cdata_wr` holds its value outside WRITE. Its content there is don't-care.

## Timing
- Reset value of every output is 0: busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel.
- All outputs are registered or decoded from registered state only. No combinational path from `cdata_rd` to any output.
- `start` sampled at edge t → `busy` = 1 and the first `crd` at t+1.
- Per window: 4 + RD_LAT + 1 cycles (6 at default).
- Full frame: 1024 × 6 = 6144 cycles, then 1 FIN cycle.
- Reset mid-operation
  - Outputs drop immediately (asynchronous).
  - Counters and `max_reg` clear; the block returns to IDLE.
  - A partial layer-1 frame is not resumed.
- `start` coincident with the FIN cycle is ignored. The controller re-issues it after `done`.

## Structure
- Shared package `conv_pkg`: DATA_WIDTH, IMG_W, address width (12), the csel codes SEL_L0 and SEL_L1, and the FSM state enumeration.
- One natural sub-module, `pool_addr_gen`:
  - holds r, c and k;
  - produces `caddr_rd` and `caddr_wr`;
  - flags the last tap and the last window.
- FSM, comparator and `max_reg` stay in the top level.

## Test plan
- Single window: layer-0 (0,0)=5, (0,1)=9, (1,0)=−3, (1,1)=9 → write to address 0 with value 9; exactly one `cwr` for that window.
- Address sweep: layer 0 filled with value = address → every layer-1 entry n = r·32+c holds (2r+1)·64 + 2c+1. `done` occurs 6145 cycles after `start`.
- Negative and tie data: window all 20'hFFFFF (−1) → written −1. Ties between taps must still produce the single max value.
- Handshake: `start` pulsed while busy at cycles 100 and 3000 → no restart; exactly 1024 writes; `done` high exactly one cycle.
- Reset mid-frame: assert `reset` at window 500 → all outputs 0 in the same cycle. A new `start` afterwards produces a full 1024-write frame beginning at address 0.
- Protocol checker over all tests:
  - `crd` & `cwr` never both high;
  - `csel` = SEL_L0 whenever `crd`, SEL_L1 whenever `cwr`;
  - no read address ≥ 4096.
